sobel_gradient: RTL and testbench
=================================

SOBEL_GRADIENT -- requirements
Module: sobel_gradient

Interface
REQ-001 The module SHALL have no parameters; all widths are fixed as stated below.
REQ-002 clk  input  1  single clock for the block; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 col_valid  input  1  upstream presents a pixel column this cycle.
REQ-005 col_ready  output  1  block can accept a column this cycle.
REQ-006 col_sol  input  1  start-of-line; qualified by col_valid, marks the first column of a row.
REQ-007 col_top, col_mid, col_bot  input  8 each  unsigned pixels, rows y-1, y, y+1 of the incoming column.
REQ-008 gx  output  11  signed horizontal gradient, two's complement.
REQ-009 gy  output  11  signed vertical gradient, two's complement.
REQ-010 grad_valid  output  1  gx/gy hold a valid result.
REQ-011 grad_ready  input  1  downstream (magnitude stage) accepts the result this cycle.
REQ-012 grad_count  output  16  number of results handed off since reset.

Function
REQ-013 A column SHALL be accepted on a rising clk edge where col_valid && col_ready.
REQ-014 col_ready SHALL equal !grad_valid || grad_ready (single output register, no bubble under full throughput).
REQ-015 A result SHALL be handed off on a rising clk edge where grad_valid && grad_ready; grad_count SHALL then increment by 1, wrapping 0xFFFF -> 0x0000.
REQ-016 The window SHALL hold three columns C0 (oldest), C1, C2 (newest), each column holding top/mid/bot pixels; on acceptance C0<=C1, C1<=C2, C2<=incoming column.
REQ-017 Fill FSM states: EMPTY (0 valid columns), ONE, TWO, RUN (>=3 valid columns in the current row).
REQ-018 On acceptance with col_sol=1, the next state SHALL be ONE regardless of the current state, with no result generated.
REQ-019 On acceptance with col_sol=0, EMPTY->ONE, ONE->TWO, TWO->RUN and RUN->RUN.
REQ-020 No state change or window shift SHALL occur without acceptance.
REQ-021 When an acceptance takes the FSM into RUN or keeps it in RUN, gx/gy SHALL be loaded from the post-shift window and grad_valid set to 1 on that same edge (latency 1 cycle from acceptance to grad_valid).
REQ-022 gx SHALL be computed as (C2.top + 2*C2.mid + C2.bot) - (C0.top + 2*C0.mid + C0.bot).
REQ-023 gy SHALL be computed as (C0.top + 2*C1.top + C2.top) - (C0.bot + 2*C1.bot + C2.bot).
REQ-024 All arithmetic SHALL be exact in at least 11-bit signed; range is -1020..+1020; no saturation and no overflow.
REQ-025 On an edge with a handoff and no new result loaded, grad_valid SHALL clear to 0.
REQ-026 On an edge with both a handoff and a new result, grad_valid SHALL stay 1 and gx/gy SHALL take the new values.
REQ-027 While grad_valid=1 and grad_ready=0, gx, gy and grad_valid SHALL hold stable and col_ready SHALL be 0.
REQ-028 Acceptance from EMPTY, ONE, or TWO->TWO transitions SHALL NOT alter gx/gy/grad_valid except per REQ-025.
REQ-029 The first accepted column after reset SHALL be treated as start-of-line even if col_sol=0.

Reset
REQ-030 On rst_n=0, asynchronously: gx=0, gy=0, grad_valid=0, grad_count=0, window pixels=0, FSM=EMPTY.
REQ-031 col_ready SHALL be 1 while in reset and on the first cycle after deassertion.
REQ-032 Reset asserted mid-row SHALL discard the window and any pending result, with no handoff counted.

Verification
REQ-033 Reset, then hold grad_ready=1 and send columns (0,0,0) sol=1, (0,0,0), (255,255,255) -> one result 1 cycle after the third acceptance: gx=+1020, gy=0, grad_count=1.
REQ-034 Send columns (255,255,255) sol=1, (255,255,255), (0,0,0) -> gx=-1020 (11'h404), gy=0.
REQ-035 Send three columns each (255,128,0) -> gy=+1020, gx=0; send a 4th column (255,128,0) -> second result, identical values, back-to-back with grad_valid held high.
REQ-036 Hold grad_ready=0 with a result pending, then drive col_valid=1 for 5 cycles -> col_ready=0, gx/gy stable, FSM frozen; release grad_ready -> exactly one handoff and resumed acceptance.
REQ-037 In RUN, send a column with col_sol=1 followed by one more column -> no result for either; the third column of the new row produces the next result.
REQ-038 Assert rst_n=0 while grad_valid=1 -> grad_valid=0 immediately, grad_count=0; the next two accepted columns produce no result.

Source files
------------

// File: rtl/sobel_gradient.sv
// 3x3 Sobel gradient over a streamed column window; emits signed gx/gy per
// pixel once three columns of the current row are held, with a single output register.
module sobel_gradient (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               col_valid,
    output logic               col_ready,
    input  logic               col_sol,
    input  logic [7:0]         col_top,
    input  logic [7:0]         col_mid,
    input  logic [7:0]         col_bot,
    output logic signed [10:0] gx,
    output logic signed [10:0] gy,
    output logic               grad_valid,
    input  logic               grad_ready,
    output logic [15:0]        grad_count
);

    typedef struct packed {
        logic [7:0] top;
        logic [7:0] mid;
        logic [7:0] bot;
    } col_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO, RUN} fill_e;

    // 1-2-1 weighted column/row sum; max 1020 fits 10 bits unsigned
    function automatic logic [9:0] wsum(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    fill_e             state, state_nxt;
    col_t              c1, c2, col_in;
    logic              accept, handoff, load;
    logic signed [10:0] gx_nxt, gy_nxt;

    assign col_in    = '{top: col_top, mid: col_mid, bot: col_bot};
    assign col_ready = !grad_valid || grad_ready;
    assign accept    = col_valid && col_ready;
    assign handoff   = grad_valid && grad_ready;

    // The oldest column is only needed as the post-shift C0, which is the
    // current c1, so only two columns are stored.
    assign gx_nxt = $signed({1'b0, wsum(col_in.top, col_in.mid, col_in.bot)}
                          - {1'b0, wsum(c1.top, c1.mid, c1.bot)});
    assign gy_nxt = $signed({1'b0, wsum(c1.top, c2.top, col_in.top)}
                          - {1'b0, wsum(c1.bot, c2.bot, col_in.bot)});

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        if (accept) begin
            if (col_sol) begin
                state_nxt = ONE;
            end else begin
                case (state)
                    EMPTY:   state_nxt = ONE;
                    ONE:     state_nxt = TWO;
                    default: begin
                        state_nxt = RUN;
                        load      = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            c1         <= '0;
            c2         <= '0;
            gx         <= '0;
            gy         <= '0;
            grad_valid <= 1'b0;
            grad_count <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                c1 <= c2;
                c2 <= col_in;
            end
            if (load) begin
                gx         <= gx_nxt;
                gy         <= gy_nxt;
                grad_valid <= 1'b1;
            end else if (handoff) begin
                grad_valid <= 1'b0;
            end
            if (handoff)
                grad_count <= grad_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_sobel_gradient.sv
// Bench for sobel_gradient: directed vector table, stall/reset sequences,
// and random traffic checked against a row-queue reference model.
module tb_sobel_gradient;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               col_valid, col_sol, grad_ready;
    logic [7:0]         col_top, col_mid, col_bot;
    logic               col_ready, grad_valid;
    logic signed [10:0] gx, gy;
    logic [15:0]        grad_count;

    int errors = 0;
    int checks = 0;

    sobel_gradient dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .col_valid  (col_valid),
        .col_ready  (col_ready),
        .col_sol    (col_sol),
        .col_top    (col_top),
        .col_mid    (col_mid),
        .col_bot    (col_bot),
        .gx         (gx),
        .gy         (gy),
        .grad_valid (grad_valid),
        .grad_ready (grad_ready),
        .grad_count (grad_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sol, t, m, b;
        int ev, egx, egy, ecnt;
    } vec_t;

    typedef struct {
        int t, m, b;
    } pix_t;

    vec_t tbl[13];

    // reference model state
    pix_t row[$];
    bit   m_first;
    int   m_valid, m_gx, m_gy, m_count;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int cv, input int sol, input int t, input int m, input int b,
                         input int gr);
        col_valid  = cv[0];
        col_sol    = sol[0];
        col_top    = 8'(t);
        col_mid    = 8'(m);
        col_bot    = 8'(b);
        grad_ready = gr[0];
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        drive(0, 0, 0, 0, 0, 1);
        rst_n = 1'b0;
        #1;
        chk("reset col_ready", int'(col_ready), 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post-reset col_ready", int'(col_ready), 1);
        row.delete();
        m_first = 1'b1;
        m_valid = 0; m_gx = 0; m_gy = 0; m_count = 0;
    endtask

    // One clock edge of the model, from the inputs seen before the edge.
    task automatic model_edge(input int cv, input int sol, input int t, input int m,
                              input int b, input int gr);
        int   rdy, acc, hand, newres;
        pix_t p;
        rdy    = (!m_valid || gr) ? 1 : 0;
        acc    = cv && rdy;
        hand   = m_valid && gr;
        newres = 0;
        if (hand) m_count = (m_count + 1) % 65536;
        if (acc) begin
            if (sol || m_first) row.delete();
            m_first = 1'b0;
            p = '{t, m, b};
            row.push_back(p);
            if (row.size() > 3) void'(row.pop_front());
            if (row.size() == 3) begin
                m_gx = (row[2].t + 2*row[2].m + row[2].b) - (row[0].t + 2*row[0].m + row[0].b);
                m_gy = (row[0].t + 2*row[1].t + row[2].t) - (row[0].b + 2*row[1].b + row[2].b);
                newres = 1;
            end
        end
        if (newres) m_valid = 1;
        else if (hand) m_valid = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 1);

        // sol, top, mid, bot, exp grad_valid, gx, gy, grad_count
        tbl[0]  = '{1,   0,   0,   0, 0,     0,    0, 0};
        tbl[1]  = '{0,   0,   0,   0, 0,     0,    0, 0};
        tbl[2]  = '{0, 255, 255, 255, 1,  1020,    0, 0};
        tbl[3]  = '{1, 255, 255, 255, 0,  1020,    0, 1};
        tbl[4]  = '{0, 255, 255, 255, 0,  1020,    0, 1};
        tbl[5]  = '{0,   0,   0,   0, 1, -1020,    0, 1};
        tbl[6]  = '{1, 255, 128,   0, 0, -1020,    0, 2};
        tbl[7]  = '{0, 255, 128,   0, 0, -1020,    0, 2};
        tbl[8]  = '{0, 255, 128,   0, 1,     0, 1020, 2};
        tbl[9]  = '{0, 255, 128,   0, 1,     0, 1020, 3};
        tbl[10] = '{1,  10,  20,  30, 0,     0, 1020, 4};
        tbl[11] = '{0,   1,   2,   3, 0,     0, 1020, 4};
        tbl[12] = '{0,   5,   6,   7, 1,   -56,  -26, 4};

        do_reset();
        chk("reset grad_valid", int'(grad_valid), 0);
        chk("reset gx", int'(gx), 0);
        chk("reset gy", int'(gy), 0);
        chk("reset grad_count", int'(grad_count), 0);

        foreach (tbl[i]) begin
            drive(1, tbl[i].sol, tbl[i].t, tbl[i].m, tbl[i].b, 1);
            #1;
            chk($sformatf("vec%0d col_ready", i), int'(col_ready), 1);
            cyc();
            chk($sformatf("vec%0d grad_valid", i), int'(grad_valid), tbl[i].ev);
            chk($sformatf("vec%0d gx", i), int'(gx), tbl[i].egx);
            chk($sformatf("vec%0d gy", i), int'(gy), tbl[i].egy);
            chk($sformatf("vec%0d grad_count", i), int'(grad_count), tbl[i].ecnt);
        end

        // Backpressure: pending result, columns offered while stalled
        do_reset();
        drive(1, 1, 0, 0, 0, 0);         cyc();
        drive(1, 0, 0, 0, 0, 0);         cyc();
        drive(1, 0, 255, 255, 255, 0);   cyc();
        chk("stall setup grad_valid", int'(grad_valid), 1);
        drive(1, 0, 50, 50, 50, 0);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("stall%0d col_ready", k), int'(col_ready), 0);
            cyc();
            chk($sformatf("stall%0d grad_valid", k), int'(grad_valid), 1);
            chk($sformatf("stall%0d gx", k), int'(gx), 1020);
            chk($sformatf("stall%0d grad_count", k), int'(grad_count), 0);
        end
        drive(0, 0, 0, 0, 0, 1);         cyc();
        chk("release grad_valid", int'(grad_valid), 0);
        chk("release grad_count", int'(grad_count), 1);
        // frozen window C0=0,C1=255 gives gx=400; a shifted window would give 200
        drive(1, 0, 100, 100, 100, 0);   cyc();
        chk("resume grad_valid", int'(grad_valid), 1);
        chk("resume gx", int'(gx), 400);
        chk("resume gy", int'(gy), 0);

        // Asynchronous reset with a result pending
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst grad_valid", int'(grad_valid), 0);
        chk("async rst grad_count", int'(grad_count), 0);
        chk("async rst gx", int'(gx), 0);
        chk("async rst col_ready", int'(col_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 0, 0, 0, 1);         cyc();
        chk("after rst col1 grad_valid", int'(grad_valid), 0);
        drive(1, 0, 0, 0, 0, 1);         cyc();
        chk("after rst col2 grad_valid", int'(grad_valid), 0);
        drive(1, 0, 1, 1, 1, 1);         cyc();
        chk("after rst col3 grad_valid", int'(grad_valid), 1);
        chk("after rst col3 gx", int'(gx), 4);
        chk("after rst col3 grad_count", int'(grad_count), 0);

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            int cv, sol, t, m, b, gr, sel;
            cv  = ($urandom % 4 != 0) ? 1 : 0;
            sol = ($urandom % 8 == 0) ? 1 : 0;
            gr  = ($urandom % 3 != 0) ? 1 : 0;
            sel = $urandom % 4;
            t = (sel == 0) ? 255 : (sel == 1) ? 0 : int'($urandom % 256);
            m = int'($urandom % 256);
            b = (sel == 0) ? 0 : (sel == 1) ? 255 : int'($urandom % 256);
            drive(cv, sol, t, m, b, gr);
            #1;
            chk("rnd col_ready", int'(col_ready), (!m_valid || gr) ? 1 : 0);
            cyc();
            model_edge(cv, sol, t, m, b, gr);
            chk("rnd grad_valid", int'(grad_valid), m_valid);
            chk("rnd gx", int'(gx), m_gx);
            chk("rnd gy", int'(gy), m_gy);
            chk("rnd grad_count", int'(grad_count), m_count);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
